// File: rtl/arm_pkg.sv
// Shared types for the multicycle ARM controller: state encoding, datapath
// select encodings and the control word produced by the output decoder.
package arm_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   localparam logic [1:0] SRC_B_RM      = 2'b00;
   localparam logic [1:0] SRC_B_EXT_IMM = 2'b01;
   localparam logic [1:0] SRC_B_FOUR    = 2'b10;

   localparam logic [1:0] RESULT_ALU_OUT    = 2'b00;
   localparam logic [1:0] RESULT_DATA       = 2'b01;
   localparam logic [1:0] RESULT_ALU_RESULT = 2'b10;

   typedef struct packed {
      logic       ir_write;
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       branch;
      logic       alu_op;
      logic       adr_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] result_src;
   } ctrl_t;

endpackage

// File: rtl/main_fsm_out_dec.sv
// Moore output decode for main_fsm: maps the current state to its control word.
module main_fsm_out_dec
   import arm_pkg::*;
(
   input  state_t state,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.adr_src    = 1'b0;
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.result_src = RESULT_ALU_RESULT;
            ctrl.ir_write   = 1'b1;
            ctrl.next_pc    = 1'b1;
         end
         DECODE: begin
            ctrl.alu_src_a  = 1'b1;
            ctrl.alu_src_b  = SRC_B_FOUR;
            ctrl.result_src = RESULT_ALU_RESULT;
         end
         MEMADR: begin
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRC_B_EXT_IMM;
         end
         MEMREAD: begin
            ctrl.result_src = RESULT_ALU_OUT;
            ctrl.adr_src    = 1'b1;
         end
         MEMWB: begin
            ctrl.result_src = RESULT_DATA;
            ctrl.reg_w      = 1'b1;
         end
         MEMWRITE: begin
            ctrl.result_src = RESULT_ALU_OUT;
            ctrl.adr_src    = 1'b1;
            ctrl.mem_w      = 1'b1;
         end
         EXECUTER: begin
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRC_B_RM;
            ctrl.alu_op    = 1'b1;
         end
         EXECUTEI: begin
            ctrl.alu_src_a = 1'b0;
            ctrl.alu_src_b = SRC_B_EXT_IMM;
            ctrl.alu_op    = 1'b1;
         end
         ALUWB: begin
            ctrl.result_src = RESULT_ALU_OUT;
            ctrl.reg_w      = 1'b1;
         end
         BRANCH: begin
            ctrl.alu_src_a  = 1'b0;
            ctrl.alu_src_b  = SRC_B_EXT_IMM;
            ctrl.result_src = RESULT_ALU_RESULT;
            ctrl.branch     = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle ARM main controller FSM. Define MEM_WAIT_EN to add a mem_ready
// handshake that stalls FETCH, MEMREAD and MEMWRITE until memory responds.
module main_fsm
   import arm_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
`ifdef MEM_WAIT_EN
   input  logic       mem_ready,
`endif
   input  logic [1:0] op,
   input  logic [5:0] funct,
   output logic       ir_write,
   output logic       next_pc,
   output logic       reg_w,
   output logic       mem_w,
   output logic       branch,
   output logic       alu_op,
   output logic       adr_src,
   output logic       undef_instr,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic [3:0] state_o
);

   state_t state;
   ctrl_t  dec_ctrl;
   ctrl_t  out_ctrl;
   logic   mem_rdy;

`ifdef MEM_WAIT_EN
   assign mem_rdy = mem_ready;
`else
   assign mem_rdy = 1'b1;
`endif

   // op/funct are only consulted in DECODE and MEMADR; every other state
   // advances unconditionally or waits on memory.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH:    if (mem_rdy) state <= DECODE;
            DECODE: begin
               case (op)
                  2'b00:   state <= funct[5] ? EXECUTEI : EXECUTER;
                  2'b01:   state <= MEMADR;
                  2'b10:   state <= BRANCH;
                  default: state <= FETCH;
               endcase
            end
            MEMADR:   state <= funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  if (mem_rdy) state <= MEMWB;
            MEMWRITE: if (mem_rdy) state <= FETCH;
            EXECUTER: state <= ALUWB;
            EXECUTEI: state <= ALUWB;
            MEMWB:    state <= FETCH;
            ALUWB:    state <= FETCH;
            BRANCH:   state <= FETCH;
            default:  state <= FETCH;
         endcase
      end
   end

   main_fsm_out_dec u_out_dec (
      .state (state),
      .ctrl  (dec_ctrl)
   );

   // A stalled fetch must not latch the instruction or advance the PC, and
   // reset silences every strobe while parking the selects at their FETCH values.
   always_comb begin
      out_ctrl = dec_ctrl;
      if (state == FETCH && !mem_rdy) begin
         out_ctrl.ir_write = 1'b0;
         out_ctrl.next_pc  = 1'b0;
      end
      if (!reset_n) begin
         out_ctrl            = '0;
         out_ctrl.alu_src_a  = 1'b1;
         out_ctrl.alu_src_b  = SRC_B_FOUR;
         out_ctrl.result_src = RESULT_ALU_RESULT;
      end
   end

   assign ir_write    = out_ctrl.ir_write;
   assign next_pc     = out_ctrl.next_pc;
   assign reg_w       = out_ctrl.reg_w;
   assign mem_w       = out_ctrl.mem_w;
   assign branch      = out_ctrl.branch;
   assign alu_op      = out_ctrl.alu_op;
   assign adr_src     = out_ctrl.adr_src;
   assign alu_src_a   = out_ctrl.alu_src_a;
   assign alu_src_b   = out_ctrl.alu_src_b;
   assign result_src  = out_ctrl.result_src;
   assign undef_instr = reset_n && (state == DECODE) && (op == 2'b11);
   assign state_o     = state;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: directed instruction sequences push expected
// per-cycle outputs; a negedge monitor pops and compares. Honors MEM_WAIT_EN.
module tb_main_fsm;
   import arm_pkg::*;

   typedef struct {
      string       name;
      logic [16:0] vec;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       mem_ready = 1'b1;
   logic [1:0] op = 2'b00;
   logic [5:0] funct = 6'b000000;
   logic       ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src;
   logic       undef_instr, alu_src_a;
   logic [1:0] alu_src_b, result_src;
   logic [3:0] state_o;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   main_fsm dut (
      .clk         (clk),
      .reset_n     (reset_n),
`ifdef MEM_WAIT_EN
      .mem_ready   (mem_ready),
`endif
      .op          (op),
      .funct       (funct),
      .ir_write    (ir_write),
      .next_pc     (next_pc),
      .reg_w       (reg_w),
      .mem_w       (mem_w),
      .branch      (branch),
      .alu_op      (alu_op),
      .adr_src     (adr_src),
      .undef_instr (undef_instr),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .result_src  (result_src),
      .state_o     (state_o)
   );

   // Hand table of per-state outputs; layout {state, ir, npc, regw, memw,
   // br, aluop, adr, undef, srca, srcb, res}.
   function automatic logic [16:0] expect_vec(input logic [3:0] st, input logic rn,
                                              input logic und, input logic mr);
      logic ir, np, rw, mw, br, aop, adr, sa;
      logic [1:0] sbv, rs;
      {ir, np, rw, mw, br, aop, adr, sa} = 8'b0;
      sbv = 2'b00;
      rs  = 2'b00;
      if (!rn) begin
         sa = 1'b1; sbv = 2'b10; rs = 2'b10;
      end else begin
         case (st)
            4'd0: begin ir = mr; np = mr; sa = 1'b1; sbv = 2'b10; rs = 2'b10; end
            4'd1: begin sa = 1'b1; sbv = 2'b10; rs = 2'b10; end
            4'd2: begin sbv = 2'b01; end
            4'd3: begin adr = 1'b1; end
            4'd4: begin rs = 2'b01; rw = 1'b1; end
            4'd5: begin adr = 1'b1; mw = 1'b1; end
            4'd6: begin aop = 1'b1; end
            4'd7: begin aop = 1'b1; sbv = 2'b01; end
            4'd8: begin rw = 1'b1; end
            4'd9: begin sbv = 2'b01; rs = 2'b10; br = 1'b1; end
            default: ;
         endcase
      end
      return {st, ir, np, rw, mw, br, aop, adr, und, sa, sbv, rs};
   endfunction

   task automatic apply_stimulus(input string name, input logic rn, input logic [1:0] o,
                                 input logic [5:0] f, input logic mr,
                                 input logic [3:0] st, input logic und);
      exp_t e;
      @(posedge clk);
      #1;
      reset_n   = rn;
      op        = o;
      funct     = f;
      mem_ready = mr;
      e.name = name;
      e.vec  = expect_vec(st, rn, und, mr);
      sb.push_back(e);
   endtask

   task automatic check_output(input exp_t e);
      logic [16:0] act;
      act = {state_o, ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src,
             undef_instr, alu_src_a, alu_src_b, result_src};
      total++;
      if (act !== e.vec) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", e.name, act, e.vec);
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) check_output(sb.pop_front());
      end
   end

   initial begin
      apply_stimulus("rst_hold",      1'b0, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("dp_fetch",      1'b1, 2'b11, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("dp_decode",     1'b1, 2'b00, 6'b101001, 1'b1, DECODE,   1'b0);
      apply_stimulus("dp_executei",   1'b1, 2'b11, 6'b000000, 1'b1, EXECUTEI, 1'b0);
      apply_stimulus("dp_aluwb",      1'b1, 2'b10, 6'b000000, 1'b1, ALUWB,    1'b0);
      apply_stimulus("ld_fetch",      1'b1, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("ld_decode",     1'b1, 2'b01, 6'b000001, 1'b1, DECODE,   1'b0);
      apply_stimulus("ld_memadr",     1'b1, 2'b01, 6'b000001, 1'b1, MEMADR,   1'b0);
      apply_stimulus("ld_memread",    1'b1, 2'b11, 6'b000000, 1'b1, MEMREAD,  1'b0);
      apply_stimulus("ld_memwb",      1'b1, 2'b00, 6'b000000, 1'b1, MEMWB,    1'b0);
      apply_stimulus("st_fetch",      1'b1, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("st_decode",     1'b1, 2'b01, 6'b100000, 1'b1, DECODE,   1'b0);
      apply_stimulus("st_memadr",     1'b1, 2'b01, 6'b100000, 1'b1, MEMADR,   1'b0);
      apply_stimulus("st_memwrite",   1'b1, 2'b00, 6'b000000, 1'b1, MEMWRITE, 1'b0);
      apply_stimulus("br_fetch",      1'b1, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("br_decode",     1'b1, 2'b10, 6'b000000, 1'b1, DECODE,   1'b0);
      apply_stimulus("br_branch",     1'b1, 2'b00, 6'b000001, 1'b1, BRANCH,   1'b0);
      apply_stimulus("ud_fetch",      1'b1, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("ud_decode",     1'b1, 2'b11, 6'b111111, 1'b1, DECODE,   1'b1);
      apply_stimulus("ud_back_fetch", 1'b1, 2'b11, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("dr_decode",     1'b1, 2'b00, 6'b000001, 1'b1, DECODE,   1'b0);
      apply_stimulus("dr_executer",   1'b1, 2'b00, 6'b000000, 1'b1, EXECUTER, 1'b0);
      apply_stimulus("dr_aluwb",      1'b1, 2'b00, 6'b000000, 1'b1, ALUWB,    1'b0);
      apply_stimulus("rs_fetch",      1'b1, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("rs_decode",     1'b1, 2'b00, 6'b000000, 1'b1, DECODE,   1'b0);
      apply_stimulus("rs_in_executer",1'b0, 2'b00, 6'b000000, 1'b1, EXECUTER, 1'b0);
      apply_stimulus("rs_hold",       1'b0, 2'b01, 6'b000001, 1'b1, FETCH,    1'b0);
      apply_stimulus("rs_release",    1'b1, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("rs2_decode",    1'b1, 2'b01, 6'b000000, 1'b1, DECODE,   1'b0);
      apply_stimulus("rs2_memadr",    1'b1, 2'b01, 6'b000000, 1'b1, MEMADR,   1'b0);
      apply_stimulus("rs2_memwrite",  1'b0, 2'b00, 6'b000000, 1'b1, MEMWRITE, 1'b0);
      apply_stimulus("rs2_fetch",     1'b1, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
`ifdef MEM_WAIT_EN
      apply_stimulus("mw_decode",     1'b1, 2'b01, 6'b000000, 1'b1, DECODE,   1'b0);
      apply_stimulus("mw_memadr",     1'b1, 2'b01, 6'b000000, 1'b1, MEMADR,   1'b0);
      for (int i = 0; i < 3; i++)
         apply_stimulus("mw_write_wait", 1'b1, 2'b00, 6'b000000, 1'b0, MEMWRITE, 1'b0);
      apply_stimulus("mw_write_done", 1'b1, 2'b00, 6'b000000, 1'b1, MEMWRITE, 1'b0);
      apply_stimulus("mw_fetch_wait", 1'b1, 2'b00, 6'b000000, 1'b0, FETCH,    1'b0);
      apply_stimulus("mw_fetch_wait", 1'b1, 2'b00, 6'b000000, 1'b0, FETCH,    1'b0);
      apply_stimulus("mw_fetch_go",   1'b1, 2'b00, 6'b000000, 1'b1, FETCH,    1'b0);
      apply_stimulus("mw_decode2",    1'b1, 2'b00, 6'b000000, 1'b1, DECODE,   1'b0);
`endif
      for (int i = 0; i < 4 && sb.size() != 0; i++) @(posedge clk);
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates occur on its rising edge.
REQ-002 SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-003 SHALL have port op, input, 2 bits: instruction op field; 00 = data-processing, 01 = memory, 10 = branch, 11 = undefined.
REQ-004 SHALL have port funct, input, 6 bits: funct[5] is the immediate (I) bit; funct[0] is the S bit for data-processing and the L bit for memory.
REQ-005 SHALL have outputs ir_write, next_pc, reg_w, mem_w, branch, alu_op, adr_src, undef_instr, each 1 bit, decoded from the current state.
REQ-006 SHALL have outputs alu_src_a (1 bit; 0 = Rn, 1 = PC), alu_src_b (2 bits; 00 = Rm, 01 = ExtImm, 10 = constant 4) and result_src (2 bits; 00 = ALUOut, 01 = Data, 10 = ALUResult).
REQ-007 SHALL have output state_o, 4 bits: current state encoding, for debug.

Function
REQ-008 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-009 SHALL use these transitions:
- FETCH -> DECODE.
- DECODE -> MEMADR when op=01; EXECUTEI when op=00 and I=1; EXECUTER when op=00 and I=0; BRANCH when op=10; FETCH when op=11.
- MEMADR -> MEMREAD when L=1; MEMWRITE when L=0.
- MEMREAD -> MEMWB.
- MEMWB, MEMWRITE, BRANCH -> FETCH.
- EXECUTER and EXECUTEI -> ALUWB.
- ALUWB -> FETCH.
REQ-010 SHALL decode outputs per state; any signal not listed is 0 and any select not listed is 00:
- FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, result_src=10, ir_write=1, next_pc=1.
- DECODE: alu_src_a=1, alu_src_b=10, result_src=10.
- MEMADR: alu_src_a=0, alu_src_b=01.
- MEMREAD: result_src=00, adr_src=1.
- MEMWB: result_src=01, reg_w=1.
- MEMWRITE: result_src=00, adr_src=1, mem_w=1.
- EXECUTER: alu_src_a=0, alu_src_b=00, alu_op=1.
- EXECUTEI: alu_src_a=0, alu_src_b=01, alu_op=1.
- ALUWB: result_src=00, reg_w=1.
- BRANCH: alu_src_a=0, alu_src_b=01, result_src=10, branch=1.
REQ-011 SHALL assert undef_instr only in a DECODE cycle with op=11; the FSM then returns to FETCH with no write strobe asserted.
REQ-012 SHALL take fixed latencies (FETCH to next FETCH) of 4 cycles for data-processing, 5 for loads, 4 for stores and 3 for branches.
REQ-013 SHALL sample op and funct only in DECODE and MEMADR; their values in other states have no effect.
REQ-014 SHALL NOT qualify reg_w by the S bit or by CMP/TST no-write; that gating is the ALU decoder's and condition logic's job.

Reset
REQ-015 SHALL load FETCH on the first rising clk edge with reset_n=0, including when reset occurs mid-instruction in any state.
REQ-016 SHALL force ir_write, next_pc, reg_w, mem_w, branch and undef_instr to 0 combinationally while reset_n=0; select outputs take their FETCH values.

Configuration
REQ-017 With MEM_WAIT_EN defined, the block SHALL add input port mem_ready (1 bit).
REQ-018 With MEM_WAIT_EN defined, FETCH, MEMREAD and MEMWRITE SHALL hold their state while mem_ready=0.
REQ-019 With MEM_WAIT_EN defined, ir_write and next_pc SHALL be asserted only in the FETCH cycle where mem_ready=1; mem_w SHALL stay asserted in MEMWRITE until mem_ready=1.
REQ-020 Without MEM_WAIT_EN, the block SHALL have no mem_ready port and SHALL behave as if mem_ready were tied to 1.

Structure
REQ-021 Package arm_pkg SHALL hold the state enum (4-bit) and named constants for the alu_src_b and result_src encodings.
REQ-022 The output decode SHALL live in one sub-module, main_fsm_out_dec (state in, control word out); the state register and next-state logic stay in main_fsm.

Verification
REQ-023 Scenario 1: reset_n=0 for 2 cycles in EXECUTER -> state_o=FETCH; reg_w, mem_w and ir_write are 0 throughout.
REQ-024 Scenario 2: op=00, funct=6'b101001 (immediate, S=1) -> FETCH, DECODE, EXECUTEI (alu_op=1, alu_src_b=01), ALUWB (reg_w=1), FETCH.
REQ-025 Scenario 3: op=01, funct[0]=1 -> FETCH, DECODE, MEMADR, MEMREAD (adr_src=1), MEMWB (result_src=01, reg_w=1); 5 cycles total.
REQ-026 Scenario 4: op=10 -> BRANCH has branch=1, alu_src_b=01; next state FETCH after 3 cycles.
REQ-027 Scenario 5: op=11 -> undef_instr=1 for exactly one DECODE cycle, then FETCH; no write strobe asserted.
REQ-028 Scenario 6 (MEM_WAIT_EN): store with mem_ready=0 for 3 cycles in MEMWRITE -> mem_w=1 for 4 cycles, exit on the 4th cycle when mem_ready=1.
